// File: rtl/ram1_mem_port.sv
// ram1_mem_port: memory-stage data access port onto the shared RAM1 SRAM.
// A write runs setup / strobe / hold phases so that address and data are
// stable for one cycle on each side of the ram1_we low window. A read
// holds ram1_oe low for two cycles and samples the bus on the edge that
// leaves the second one. Fetch watches mem_conflict and keeps off RAM1
// while it is high.
//
// Handshake: req is a level request that the port samples only in IDLE.
// The accepting edge latches wr/addr/wdata. After that the port ignores
// req and its qualifiers until it pulses done for one cycle. The MEM
// stage drops req in that cycle. If req is still high in DONE, the port
// takes it as a new access on the edge that follows the IDLE cycle.
module ram1_mem_port #(
    parameter logic [1:0] ADDR_HI       = 2'b00,
    parameter int         WE_LOW_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        mem_conflict,
    inout  wire  [15:0] ram1_data,
    output logic [17:0] ram1_addr,
    output logic        ram1_en,
    output logic        ram1_oe,
    output logic        ram1_we
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WSETUP  = 3'd1,
        S_WSTROBE = 3'd2,
        S_WHOLD   = 3'd3,
        S_RSETUP  = 3'd4,
        S_RSAMPLE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // The strobe counter starts at 0 on entry to WSTROBE. The port leaves
    // WSTROBE when the counter reaches this value.
    localparam logic [2:0] LAST_CNT = 3'(WE_LOW_CYCLES - 1);

    // Control values that the next state wants. They are registered so
    // that the SRAM pins change only on clock edges.
    typedef struct packed {
        logic en;
        logic oe;
        logic we;
        logic drive;
        logic done;
    } ctl_t;

    state_t      state;
    state_t      next_state;
    ctl_t        ctl_next;
    logic [2:0]  cnt;
    logic [15:0] wdata_q;
    logic        drive;
    logic        accept;

    assign accept       = (state == S_IDLE) && req;
    assign busy         = (state != S_IDLE);
    assign mem_conflict = req | busy;
    assign ram1_data    = drive ? wdata_q : 16'bz;

    // State register. Reset returns to IDLE at once, independent of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Next-state decode. Unused encodings fall back to IDLE.
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:    next_state = req ? (wr ? S_WSETUP : S_RSETUP) : S_IDLE;
            S_WSETUP:  next_state = S_WSTROBE;
            S_WSTROBE: next_state = (cnt == LAST_CNT) ? S_WHOLD : S_WSTROBE;
            S_WHOLD:   next_state = S_DONE;
            S_RSETUP:  next_state = S_RSAMPLE;
            S_RSAMPLE: next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Output decode of the state being entered. we and oe are never both low.
    always_comb begin
        ctl_next = '{en: 1'b1, oe: 1'b1, we: 1'b1, drive: 1'b0, done: 1'b0};
        case (next_state)
            S_WSETUP:  begin ctl_next.en = 1'b0; ctl_next.drive = 1'b1; end
            S_WSTROBE: begin ctl_next.en = 1'b0; ctl_next.we = 1'b0; ctl_next.drive = 1'b1; end
            S_WHOLD:   begin ctl_next.en = 1'b0; ctl_next.drive = 1'b1; end
            S_RSETUP:  begin ctl_next.en = 1'b0; ctl_next.oe = 1'b0; end
            S_RSAMPLE: begin ctl_next.en = 1'b0; ctl_next.oe = 1'b0; end
            S_DONE:    ctl_next.done = 1'b1;
            default:   ctl_next.done = 1'b0;
        endcase
    end

    // Registered SRAM controls. Reset deasserts them and releases the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram1_en <= 1'b1;
            ram1_oe <= 1'b1;
            ram1_we <= 1'b1;
            drive   <= 1'b0;
            done    <= 1'b0;
        end else begin
            ram1_en <= ctl_next.en;
            ram1_oe <= ctl_next.oe;
            ram1_we <= ctl_next.we;
            drive   <= ctl_next.drive;
            done    <= ctl_next.done;
        end
    end

    // Strobe length counter. It is held at 0 outside WSTROBE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    cnt <= 3'd0;
        else if (state != S_WSTROBE) cnt <= 3'd0;
        else                         cnt <= cnt + 3'd1;
    end

    // Address and write data latch when the port accepts a request. The
    // read result is captured on the edge that leaves RSAMPLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram1_addr <= 18'd0;
            wdata_q   <= 16'd0;
            rdata     <= 16'd0;
        end else begin
            if (accept) begin
                ram1_addr <= {ADDR_HI, addr};
                wdata_q   <= wdata;
            end
            if (state == S_RSAMPLE) rdata <= ram1_data;
        end
    end

endmodule

// File: tb/tb_ram1_mem_port.sv
// tb_ram1_mem_port: directed bench for ram1_mem_port.
// Instance a uses the default parameters and a small SRAM model. That
// model drives the bus while en and oe are both low. Otherwise, when
// asked, it drives a 0x0000 probe, so any drive from the port shows up
// as a wrong value. Instance b uses WE_LOW_CYCLES=3 and ADDR_HI=2'b01.
module tb_ram1_mem_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // instance a signals
    logic        req, wr;
    logic [15:0] addr, wdata, rdata;
    logic        done, busy, mem_conflict;
    wire  [15:0] ram1_data;
    logic [17:0] ram1_addr;
    logic        ram1_en, ram1_oe, ram1_we;
    logic        probe;
    logic [15:0] mem_a [0:255];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [15:0] pre_val;

    // instance b signals
    logic        req_b, wr_b;
    logic [15:0] addr_b, wdata_b, rdata_b;
    logic        done_b, busy_b, mem_conflict_b;
    wire  [15:0] ram1_data_b;
    logic [17:0] ram1_addr_b;
    logic        ram1_en_b, ram1_oe_b, ram1_we_b;
    logic [15:0] mem_b [0:255];

    ram1_mem_port dut_a (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .done(done), .busy(busy), .mem_conflict(mem_conflict),
        .ram1_data(ram1_data), .ram1_addr(ram1_addr), .ram1_en(ram1_en),
        .ram1_oe(ram1_oe), .ram1_we(ram1_we)
    );

    ram1_mem_port #(.ADDR_HI(2'b01), .WE_LOW_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .wr(wr_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .done(done_b), .busy(busy_b), .mem_conflict(mem_conflict_b),
        .ram1_data(ram1_data_b), .ram1_addr(ram1_addr_b), .ram1_en(ram1_en_b),
        .ram1_oe(ram1_oe_b), .ram1_we(ram1_we_b)
    );

    // SRAM model a: read drive, otherwise optional probe value
    assign ram1_data = (!ram1_en && !ram1_oe) ? mem_a[ram1_addr[7:0]]
                     : (probe ? 16'h0000 : 16'hzzzz);

    always @(posedge clk) begin
        if (pre_en) mem_a[pre_addr] <= pre_val;
        else if (!ram1_en && !ram1_we) mem_a[ram1_addr[7:0]] <= ram1_data;
    end

    always @(posedge clk) begin
        if (!ram1_en_b && !ram1_we_b) mem_b[ram1_addr_b[7:0]] <= ram1_data_b;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; req = 1'b1; wr = 1'b0; addr = 16'h0; wdata = 16'h0; probe = 1'b1;
        pre_en = 1'b0; pre_addr = 8'h0; pre_val = 16'h0;
        req_b = 1'b0; wr_b = 1'b0; addr_b = 16'h0; wdata_b = 16'h0;
        repeat (2) tick();
        n_checks++; if (ram1_en !== 1'b1) begin n_fail++; $display("FAIL reset_en: got %b want 1", ram1_en); end
        n_checks++; if (ram1_oe !== 1'b1) begin n_fail++; $display("FAIL reset_oe: got %b want 1", ram1_oe); end
        n_checks++; if (ram1_we !== 1'b1) begin n_fail++; $display("FAIL reset_we: got %b want 1", ram1_we); end
        n_checks++; if (ram1_data !== 16'h0000) begin n_fail++; $display("FAIL reset_bus_released: got %h want probe 0000", ram1_data); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (mem_conflict !== 1'b1) begin n_fail++; $display("FAIL reset_conflict_req: got %b want 1", mem_conflict); end
        n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
        n_checks++; if (ram1_addr !== 18'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 00000", ram1_addr); end
        req = 1'b0;
        #1;
        n_checks++; if (mem_conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict_idle: got %b want 0", mem_conflict); end
        rst = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write(input logic [15:0] a, input logic [15:0] d);
        int we_lo, en_lo, oe_lo, bad, mc_lo, done_at;
        we_lo = 0; en_lo = 0; oe_lo = 0; bad = 0; mc_lo = 0; done_at = -1;
        probe = 1'b0; req = 1'b1; wr = 1'b1; addr = a; wdata = d;
        #1;
        n_checks++; if (mem_conflict !== 1'b1) begin n_fail++; $display("FAIL wr_conflict_early: got %b want 1", mem_conflict); end
        for (int k = 0; k < 12 && done_at < 0; k++) begin
            tick();
            if (k == 0) begin req = 1'b0; addr = 16'hFFFF; wdata = 16'hDEAD; end
            if (!ram1_we) we_lo++;
            if (!ram1_oe) oe_lo++;
            if (!mem_conflict) mc_lo++;
            if (!ram1_en) begin
                en_lo++;
                if (ram1_data !== d || ram1_addr !== {2'b00, a}) bad++;
            end
            if (done) done_at = k;
        end
        n_checks++; if (done_at != 3) begin n_fail++; $display("FAIL wr_latency: done at %0d want 3", done_at); end
        n_checks++; if (we_lo != 1) begin n_fail++; $display("FAIL wr_we_low: got %0d want 1", we_lo); end
        n_checks++; if (en_lo != 3) begin n_fail++; $display("FAIL wr_drive_window: got %0d want 3", en_lo); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wr_bus_addr_stable: %0d bad cycles want 0", bad); end
        n_checks++; if (oe_lo != 0) begin n_fail++; $display("FAIL wr_oe: %0d low cycles want 0", oe_lo); end
        n_checks++; if (mc_lo != 0) begin n_fail++; $display("FAIL wr_conflict_hold: %0d low cycles want 0", mc_lo); end
        probe = 1'b1;
        #1;
        n_checks++; if (ram1_data !== 16'h0000) begin n_fail++; $display("FAIL wr_done_bus: got %h want 0000", ram1_data); end
        n_checks++; if (ram1_addr !== {2'b00, a}) begin n_fail++; $display("FAIL wr_done_addr_hold: got %h want %h", ram1_addr, {2'b00, a}); end
        tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle: done=%b busy=%b want 0 0", done, busy); end
        n_checks++; if (mem_conflict !== 1'b0) begin n_fail++; $display("FAIL wr_conflict_release: got %b want 0", mem_conflict); end
        n_checks++; if (mem_a[a[7:0]] !== d) begin n_fail++; $display("FAIL wr_sram_word: got %h want %h", mem_a[a[7:0]], d); end
    endtask

    task automatic test_read(input logic [15:0] a, input logic [15:0] v);
        int oe_lo, we_lo, bad, done_at;
        oe_lo = 0; we_lo = 0; bad = 0; done_at = -1;
        pre_en = 1'b1; pre_addr = a[7:0]; pre_val = v;
        tick();
        pre_en = 1'b0;
        probe = 1'b1; req = 1'b1; wr = 1'b0; addr = a;
        for (int k = 0; k < 12 && done_at < 0; k++) begin
            tick();
            if (k == 0) req = 1'b0;
            if (!ram1_we) we_lo++;
            if (!ram1_oe) begin
                oe_lo++;
                if (ram1_data !== v) bad++;
            end else if (ram1_data !== 16'h0000) bad++;
            if (done) done_at = k;
        end
        n_checks++; if (done_at != 2) begin n_fail++; $display("FAIL rd_latency: done at %0d want 2", done_at); end
        n_checks++; if (oe_lo != 2) begin n_fail++; $display("FAIL rd_oe_low: got %0d want 2", oe_lo); end
        n_checks++; if (we_lo != 0) begin n_fail++; $display("FAIL rd_we: %0d low cycles want 0", we_lo); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rd_port_drove_bus: %0d bad cycles want 0", bad); end
        n_checks++; if (rdata !== v) begin n_fail++; $display("FAIL rd_data: got %h want %h", rdata, v); end
        n_checks++; if (ram1_addr !== {2'b00, a}) begin n_fail++; $display("FAIL rd_addr: got %h want %h", ram1_addr, {2'b00, a}); end
        repeat (2) tick();
        n_checks++; if (rdata !== v) begin n_fail++; $display("FAIL rd_data_held: got %h want %h", rdata, v); end
    endtask

    task automatic test_back_to_back;
        int n_done, busy_lo, both_lo, mc_lo, rd_done_at;
        n_done = 0; busy_lo = 0; both_lo = 0; mc_lo = 0; rd_done_at = -1;
        probe = 1'b0; req = 1'b1; wr = 1'b1; addr = 16'h00FF; wdata = 16'hA5A5;
        for (int k = 0; k < 16 && rd_done_at < 0; k++) begin
            tick();
            if (!ram1_we && !ram1_oe) both_lo++;
            if (!mem_conflict) mc_lo++;
            if (!busy) busy_lo++;
            if (done) begin
                n_done++;
                if (n_done == 1) wr = 1'b0;
                else begin rd_done_at = k; req = 1'b0; end
            end
        end
        n_checks++; if (rd_done_at != 7) begin n_fail++; $display("FAIL b2b_read_done: at %0d want 7", rd_done_at); end
        n_checks++; if (busy_lo != 1) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d want 1", busy_lo); end
        n_checks++; if (both_lo != 0) begin n_fail++; $display("FAIL b2b_we_oe_overlap: got %0d want 0", both_lo); end
        n_checks++; if (mc_lo != 0) begin n_fail++; $display("FAIL b2b_conflict: %0d low cycles want 0", mc_lo); end
        n_checks++; if (rdata !== 16'hA5A5) begin n_fail++; $display("FAIL b2b_rdata: got %h want a5a5", rdata); end
        tick();
        n_checks++; if (busy !== 1'b0 || mem_conflict !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: busy=%b conflict=%b want 0 0", busy, mem_conflict); end
    endtask

    task automatic test_reset_mid_write;
        int done_seen;
        done_seen = 0;
        probe = 1'b0; req = 1'b1; wr = 1'b1; addr = 16'h0020; wdata = 16'h7777;
        tick();
        req = 1'b0;
        tick();
        n_checks++; if (ram1_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_strobe: we=%b want 0", ram1_we); end
        #2;
        rst = 1'b0; probe = 1'b1;
        #1;
        n_checks++; if (ram1_we !== 1'b1 || ram1_en !== 1'b1 || ram1_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_ctl: en=%b oe=%b we=%b want 1 1 1", ram1_en, ram1_oe, ram1_we); end
        n_checks++; if (ram1_data !== 16'h0000) begin n_fail++; $display("FAIL rstmid_bus: got %h want 0000", ram1_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_state_idle: busy=%b want 0", busy); end
        tick();
        if (done) done_seen++;
        rst = 1'b1;
        repeat (4) begin
            tick();
            if (done) done_seen++;
        end
        n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_seen); end
        test_write(16'h0020, 16'h1357);
    endtask

    task automatic test_long_strobe;
        int we_lo, mc_lo, bad, done_at;
        we_lo = 0; mc_lo = 0; bad = 0; done_at = -1;
        req_b = 1'b1; wr_b = 1'b1; addr_b = 16'h0010; wdata_b = 16'h0001;
        #1;
        n_checks++; if (mem_conflict_b !== 1'b1) begin n_fail++; $display("FAIL long_conflict_early: got %b want 1", mem_conflict_b); end
        for (int k = 0; k < 16 && done_at < 0; k++) begin
            tick();
            if (k == 0) req_b = 1'b0;
            if (!ram1_we_b) we_lo++;
            if (!mem_conflict_b) mc_lo++;
            if (!ram1_en_b && ram1_data_b !== 16'h0001) bad++;
            if (done_b) done_at = k;
        end
        n_checks++; if (we_lo != 3) begin n_fail++; $display("FAIL long_we_low: got %0d want 3", we_lo); end
        n_checks++; if (done_at != 5) begin n_fail++; $display("FAIL long_latency: done at %0d want 5", done_at); end
        n_checks++; if (ram1_addr_b !== 18'h10010) begin n_fail++; $display("FAIL long_addr: got %h want 10010", ram1_addr_b); end
        n_checks++; if (mc_lo != 0) begin n_fail++; $display("FAIL long_conflict: %0d low cycles want 0", mc_lo); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL long_bus: %0d bad cycles want 0", bad); end
        n_checks++; if (mem_b[8'h10] !== 16'h0001) begin n_fail++; $display("FAIL long_sram_word: got %h want 0001", mem_b[8'h10]); end
        tick();
        n_checks++; if (mem_conflict_b !== 1'b0) begin n_fail++; $display("FAIL long_conflict_release: got %b want 0", mem_conflict_b); end
        n_checks++; if (rdata_b !== 16'h0000) begin n_fail++; $display("FAIL long_rdata_untouched: got %h want 0000", rdata_b); end
    endtask

    initial begin
        test_reset();
        test_write(16'h0040, 16'h1234);
        test_read(16'h0040, 16'hBEEF);
        test_back_to_back();
        test_reset_mid_write();
        test_long_strobe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram1_mem_port.md
Name: ram1_mem_port

Overview:
- Memory-stage access port to the shared RAM1 SRAM (18-bit address, 16-bit data). Instruction fetch reads the same SRAM.
- Performs single-word data reads and writes on RAM1 for load and store instructions.
- Generates the SRAM write strobe with explicit setup and hold phases.
- Raises mem_conflict so that fetch substitutes NOPs while this port owns the bus.

Parameters:
- ADDR_HI, 2'b00: upper two bits of ram1_addr.
- WE_LOW_CYCLES, 1: cycles ram1_we is held low per write; legal range 1-7.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-low.
- req  input  1  access request from MEM stage, level; sampled in IDLE only.
- wr  input  1  1 = write, 0 = read; sampled with req.
- addr  input  16  word address; sampled with req.
- wdata  input  16  write data; sampled with req.
- rdata  output  16  read result; registered.
- done  output  1  one-cycle pulse when the access completes.
- busy  output  1  high whenever state != IDLE.
- mem_conflict  output  1  combinational: req | busy; fetch must not touch RAM1 while high.
- ram1_data  inout  16  SRAM data bus.
- ram1_addr  output  18  SRAM address.
- ram1_en  output  1  SRAM chip enable, active-low.
- ram1_oe  output  1  SRAM output enable, active-low.
- ram1_we  output  1  SRAM write enable, active-low.

Behaviour:
- Reset (rst=0, immediate, independent of clk):
  - state=IDLE; ram1_en=1, ram1_oe=1, ram1_we=1.
  - Bus driver off (ram1_data=Z); ram1_addr=0, rdata=0, done=0, busy=0.
- States: IDLE, WSETUP, WSTROBE, WHOLD, RSETUP, RSAMPLE, DONE.
- IDLE:
  - en=1, oe=1, we=1, bus Z.
  - On req=1: latch addr/wdata/wr and set ram1_addr={ADDR_HI,addr}.
  - wr=1 -> WSETUP; wr=0 -> RSETUP.
- WSETUP (1 cycle): en=0, oe=1, we=1; bus driven with latched wdata.
- WSTROBE (WE_LOW_CYCLES cycles, internal 3-bit counter): en=0, oe=1, we=0; bus driven.
- WHOLD (1 cycle): en=0, oe=1, we=1; bus and address still driven.
- RSETUP (1 cycle): en=0, oe=0, we=1; bus Z.
- RSAMPLE (1 cycle): en=0, oe=0, we=1; bus Z. On exit edge, rdata<=ram1_data.
- DONE (1 cycle):
  - en=1, oe=1, we=1; bus Z; done=1.
  - ram1_addr holds last value.
  - -> IDLE unconditionally.
- Control outputs are registered (set on the edge entering each state). we and oe are never both 0.
- Latency, counted from the accepting edge E:
  - write: done high in the cycle after edge E+2+WE_LOW_CYCLES;
  - read: done high in the cycle after edge E+2; rdata valid from that cycle and held until the next read.
- Bus ownership:
  - Driver enabled only in WSETUP/WSTROBE/WHOLD.
  - Address and data are stable for the whole window in which we=0, plus one cycle before and one after.
- Request handling:
  - req/wr/addr/wdata changes while busy are ignored.
  - A req held high through DONE is re-accepted in IDLE on the following edge as a new access. The MEM stage must drop req on done.
- mem_conflict:
  - Asserts in the same cycle req rises, before the first edge, so fetch's mid-cycle sample sees it.
  - Deasserts the cycle after DONE if req=0.
- Reset mid-operation: any state returns to IDLE at once; we/oe/en go high and the bus is released. A write interrupted in WSTROBE is undefined in SRAM content. No done pulse.
- Any illegal state encoding -> IDLE on next edge.

Test Plan:
- Reset: hold rst=0 with req=1 -> en/oe/we=1, ram1_data=Z, done=0, mem_conflict=1 (req-driven). Release with req=0 -> mem_conflict=0.
- Write addr=0x0040, wdata=0x1234, WE_LOW_CYCLES=1:
  - ram1_addr=0x00040; bus=0x1234 from WSETUP through WHOLD.
  - we=0 for exactly 1 cycle; done 3 cycles after accept.
  - SRAM model word 0x0040 = 0x1234.
- Read addr=0x0040, model preloaded 0xBEEF:
  - oe=0 for 2 cycles, bus never driven by port; done 2 cycles after accept; rdata=0xBEEF and held.
- Back-to-back: write 0x00FF<=0xA5A5, then read 0x00FF with req held -> no cycle where port drives while oe=0; rdata=0xA5A5; busy low exactly one cycle (IDLE) between accesses.
- Reset pulse during WSTROBE -> we returns to 1 asynchronously, bus Z same time step, state IDLE, no done; next write completes normally.
- WE_LOW_CYCLES=3, ADDR_HI=2'b01, write 0x0010<=0x0001 -> we low exactly 3 cycles; ram1_addr=0x10010; done 5 cycles after accept; mem_conflict high throughout.
